// File: rtl/sc_pkg.sv
// -----------------------------------------------------------------------------
// sc_pkg
// Shared constants and types for the stochastic-computing output stage.
//   SC_WIDTH_DEFAULT : default binary sample width (window = 2^width bits)
//   SC_FILTER_ORDER  : order of the upstream stochastic FIR core
//   sc_state_e       : decoder FSM state encoding
// -----------------------------------------------------------------------------
package sc_pkg;

  localparam int unsigned SC_WIDTH_DEFAULT = 12;
  localparam int unsigned SC_FILTER_ORDER  = 18;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } sc_state_e;

endpackage

// File: rtl/sc_stream_decoder_if.sv
// -----------------------------------------------------------------------------
// sc_stream_decoder_if
// Bitstream-in / sample-out bundle of the stochastic stream decoder.
//   start       : window start pulse (aborts a running window)
//   bit_in      : stochastic bit from the FIR core
//   bit_valid   : bit_in is meaningful this cycle
//   out         : last completed binary sample (N bits)
//   done        : one-cycle strobe when out updates
//   busy        : a window is in progress
//   restart_err : one-cycle pulse when start aborts an unfinished window
// master drives the stream, slave is the decoder.
// -----------------------------------------------------------------------------
interface sc_stream_decoder_if
  import sc_pkg::*;
#(
  parameter int unsigned N = SC_WIDTH_DEFAULT
);

  logic         start;
  logic         bit_in;
  logic         bit_valid;
  logic [N-1:0] out;
  logic         done;
  logic         busy;
  logic         restart_err;

  modport master (
    output start, bit_in, bit_valid,
    input  out, done, busy, restart_err
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output out, done, busy, restart_err
  );

endinterface

// File: rtl/sc_ones_counter.sv
// -----------------------------------------------------------------------------
// sc_ones_counter
// Clearable (N+1)-bit ones counter with increment-enable and a saturating
// N-bit read-out of (count + inc), i.e. the value including the bit being
// sampled this cycle.
//   clk, reset : clock and synchronous active-high reset
//   clr        : clear the count this cycle (takes priority over inc)
//   inc        : add one to the count (also folded into sat_o)
//   seed       : value loaded into bit 0 when clearing (bit 0 of a new window)
//   sat_o      : min(count + inc, 2^N-1)
// -----------------------------------------------------------------------------
module sc_ones_counter
  import sc_pkg::*;
#(
  parameter int unsigned N = SC_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         seed,
  output logic [N-1:0] sat_o
);

  logic [N:0] cnt_q;
  logic [N:0] cnt_d;
  logic [N:0] sum_s;

  // Next count: clear (optionally seeding the first bit) or accumulate.
  always_comb begin
    sum_s = cnt_q + {{N{1'b0}}, inc};
    if (clr) begin
      cnt_d = {{N{1'b0}}, seed};
    end else begin
      cnt_d = sum_s;
    end
  end

  // An all-ones window reaches 2^N, which must clamp instead of wrapping to 0.
  always_comb begin
    if (sum_s[N]) begin
      sat_o = {N{1'b1}};
    end else begin
      sat_o = sum_s[N-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sc_stream_decoder.sv
// -----------------------------------------------------------------------------
// sc_stream_decoder
// Counts the 1s of a unipolar stochastic bitstream over windows of 2^N valid
// bits and presents each count as an N-bit binary sample.
//   clock_d : digital clock, rising edge
//   reset   : synchronous active-high reset, priority over everything
//   bus     : slave side of sc_stream_decoder_if (start/bit_in/bit_valid in,
//             out/done/busy/restart_err out, all outputs registered)
// Parameters: N (sample width), CONTINUOUS (1 = chain windows, 0 = idle after
// each window).
// -----------------------------------------------------------------------------
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int unsigned N          = SC_WIDTH_DEFAULT,
  parameter bit          CONTINUOUS = 1'b1
) (
  input logic               clock_d,
  input logic               reset,
  sc_stream_decoder_if.slave bus
);

  sc_state_e    state_q, state_d;
  logic [N-1:0] bit_cnt_q, bit_cnt_d;
  logic [N-1:0] out_q, out_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic         restart_err_q, restart_err_d;

  logic         last_bit_s;
  logic         new_win_s;
  logic         ones_clr_s;
  logic         ones_inc_s;
  logic         ones_seed_s;
  logic [N-1:0] ones_sat_s;

  assign last_bit_s = (state_q == COUNT) && bus.bit_valid && (bit_cnt_q == {N{1'b1}});
  // A start that is not absorbed by a completing window opens a new window in
  // this very cycle, so a valid bit here is already bit 0.
  assign new_win_s   = bus.start && !last_bit_s;
  assign ones_clr_s  = bus.start || last_bit_s;
  assign ones_inc_s  = (state_q == COUNT) && bus.bit_valid && bus.bit_in;
  assign ones_seed_s = new_win_s && bus.bit_valid && bus.bit_in;

  sc_ones_counter #(
    .N (N)
  ) u_ones_counter (
    .clk   (clock_d),
    .reset (reset),
    .clr   (ones_clr_s),
    .inc   (ones_inc_s),
    .seed  (ones_seed_s),
    .sat_o (ones_sat_s)
  );

  // State register and registered outputs.
  always_ff @(posedge clock_d) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      out_q         <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      restart_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      out_q         <= out_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      restart_err_q <= restart_err_d;
    end
  end

  // Next state. A start on the last bit keeps counting even in one-shot mode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = COUNT;
        else           state_d = IDLE;
      end
      COUNT: begin
        if (last_bit_s && !CONTINUOUS && !bus.start) state_d = IDLE;
        else                                         state_d = COUNT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Window counter, sample capture and status strobes.
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    out_d         = out_q;
    done_d        = 1'b0;
    restart_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) bit_cnt_d = {{(N-1){1'b0}}, bus.bit_valid};
        else           bit_cnt_d = bit_cnt_q;
      end
      COUNT: begin
        if (last_bit_s) begin
          // Natural wrap from all-ones back to zero starts the next window.
          bit_cnt_d = bit_cnt_q + {{(N-1){1'b0}}, 1'b1};
          out_d     = ones_sat_s;
          done_d    = 1'b1;
        end else if (bus.start) begin
          bit_cnt_d     = {{(N-1){1'b0}}, bus.bit_valid};
          restart_err_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + {{(N-1){1'b0}}, bus.bit_valid};
        end
      end
      default: bit_cnt_d = '0;
    endcase
    busy_d = (state_d == COUNT);
  end

  assign bus.out         = out_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.restart_err = restart_err_q;

endmodule

// File: doc/sc_stream_decoder.md
# sc_stream_decoder

Stochastic-to-binary output stage placed directly downstream of the HWA stochastic FIR core. It counts the 1s in a unipolar stochastic bitstream over a window of 2^N valid bits and presents the count as an N-bit binary sample. It raises a one-cycle `done` strobe per completed window, so one binary sample is produced per sampling period (2^N digital clocks).

## Interface
- `N`, default 12: binary sample width; window length is 2^N valid bits.
- `CONTINUOUS`, default 1: 1 = a new window starts immediately after each completed window; 0 = return to idle after each window.
- `clock_d` input 1: digital clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: window start pulse; aborts and restarts if a window is in progress.
- `bit_in` input 1: stochastic bit from the FIR core.
- `bit_valid` input 1: `bit_in` is meaningful this cycle.
- `out` output N: last completed binary sample; holds until the next window completes.
- `done` output 1: one-cycle strobe in the cycle `out` updates.
- `busy` output 1: a window is in progress.
- `restart_err` output 1: one-cycle pulse when `start` aborts an unfinished window.

## Operation
- FSM states: IDLE and COUNT. Reset state is IDLE.
- Internal counters:
  - `bit_cnt`: N bits, counts valid bits in the current window.
  - `ones_cnt`: N+1 bits, counts 1s.
- IDLE:
  - `start` = 1 moves to COUNT and clears both counters.
  - If `bit_valid` is also high in that cycle, that bit is counted as window bit 0.
- COUNT:
  - Each cycle with `bit_valid` = 1: `bit_cnt` increments and `ones_cnt` increments by `bit_in`.
  - Cycles with `bit_valid` = 0 change nothing (gaps are allowed).
- Last bit (`bit_valid` = 1 and `bit_cnt` = 2^N−1):
  - `out` ← min(`ones_cnt` + `bit_in`, 2^N−1). An all-ones window saturates to 2^N−1, never wraps to 0.
  - `done` ← 1 and both counters clear.
  - With `CONTINUOUS` = 1, stay in COUNT; the next valid bit is bit 0 of the new window.
  - With `CONTINUOUS` = 0, go to IDLE.
- `start` while in COUNT, not on the last bit:
  - Counters clear, `restart_err` = 1, no `done`, `out` is unchanged.
  - A valid bit in that cycle counts as bit 0 of the new window.
- `start` coinciding with the last bit: the window completes normally (`done`, `out` update) and a new window begins. No `restart_err`. This holds even when `CONTINUOUS` = 0.
- `bit_cnt` wraps naturally from 2^N−1 to 0; no separate wrap logic.

## Timing
- Reset values: `out` = 0, `done` = 0, `busy` = 0, `restart_err` = 0, state IDLE, counters 0.
- Latency: `out` and `done` are registered and visible the cycle after the last valid bit is sampled.
- `done` is exactly one cycle wide.
- `busy`:
  - Goes high the cycle after `start` is accepted.
  - With `CONTINUOUS` = 0, goes low together with `done`.
- `reset` mid-window discards the partial window: no `done`, and `out` returns to 0.
- `reset` has priority over `start` and over all counting.
- Throughput: with continuous `bit_valid`, one sample every 2^N cycles (4096 at N = 12). This matches the sampling-clock period.

## Structure
- Shared package `sc_pkg` holds:
  - the default width constant (12),
  - the filter order constant (18),
  - the decoder state enum (IDLE, COUNT).
- One sub-module, `sc_ones_counter`: clearable N+1-bit counter with increment-enable and saturating N-bit read-out. The FSM and output registers stay in the top module.

## Test plan
- All-zero stream, `start`, 4096 valid bits → `out` = 0 with `done` for 1 cycle at cycle 4097. `busy` falls at the same edge when `CONTINUOUS` = 0.
- All-one stream → `out` = 4095 (saturated), no wrap to 0.
- Alternating 1/0 with `bit_valid` deasserted every 3rd cycle → `out` = 2048 after exactly 4096 valid bits. The `done` cycle accounts for the gaps.
- `start` again after 1000 bits → `restart_err` pulses once, no `done`, `out` unchanged. The window completes 4096 valid bits after the restart.
- `CONTINUOUS` = 1, two back-to-back windows of 1024 then 3072 ones → `done` at cycles 4097 and 8193, `out` = 1024 then 3072.
- `reset` asserted mid-window → `out` = 0, `busy` = 0, no `done`. A subsequent `start` yields a correct full window.
